// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and widths for the I2C master arbiter slice.
package i2c_master_arbiter_pkg;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } e_arb_states;
endpackage

// File: rtl/i2c_master_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [PW-1:0]      idx_o
);
  always_comb begin
    int j;
    j        = 0;
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    // Scan farthest offset first so the closest one to ptr is the last to win.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = PW'(j);
      end
    end
    if (valid_o) onehot_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sequencer sharing one I2C master between NUM_REQ requesters,
// with a per-transaction watchdog.
module i2c_master_arbiter
  import i2c_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_rw,
  input  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [I2C_DATA_W-1:0]         rdata,
  output logic                          nack,
  output logic                          timeout,
  output logic                          m_start,
  output logic [I2C_ADDR_W-1:0]         m_addr,
  output logic                          m_rw,
  output logic [I2C_DATA_W-1:0]         m_wdata,
  input  logic                          m_busy,
  input  logic                          m_done,
  input  logic [I2C_DATA_W-1:0]         m_rdata,
  input  logic                          m_nack
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  e_arb_states               state_q, state_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]             win_q, win_d, ptr_q, ptr_d;
  logic [TO_W-1:0]           cnt_q, cnt_d;
  logic [I2C_ADDR_W-1:0]     addr_q, addr_d;
  logic                      rw_q, rw_d;
  logic [I2C_DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic                      nack_q, nack_d, to_q, to_d;

  logic                      pick_vld;
  logic [NUM_REQ-1:0]        pick_oh;
  logic [PW-1:0]             pick_idx;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_vld),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    to_d    = to_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld && !m_busy) begin
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          addr_d  = req_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
          rw_d    = req_rw[pick_idx];
          wdata_d = req_wdata[pick_idx*I2C_DATA_W +: I2C_DATA_W];
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // A completion landing on the expiry cycle is reported as a real result.
        if (m_done) begin
          rdata_d = rw_q ? m_rdata : '0;
          nack_d  = m_nack;
          to_d    = 1'b0;
          gnt_d   = '0;
          state_d = ARB_RESP;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          nack_d  = 1'b0;
          to_d    = 1'b1;
          gnt_d   = '0;
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_RESP: begin
        ptr_d   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign gnt     = gnt_q;
  assign done    = (state_q == ARB_RESP) ? (NUM_REQ'(1) << win_q) : '0;
  assign rdata   = rdata_q;
  assign nack    = nack_q;
  assign timeout = to_q;
  assign m_start = (state_q == ARB_ISSUE);
  assign m_addr  = addr_q;
  assign m_rw    = rw_q;
  assign m_wdata = wdata_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; the master side is driven by hand.
module tb_i2c_master_arbiter;
  logic        clk, rst;
  logic [3:0]  req, req_rw;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt, done;
  logic [7:0]  rdata, m_wdata, m_rdata;
  logic        nack, timeout, m_start, m_rw, m_busy, m_done, m_nack;
  logic [6:0]  m_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int k;

  i2c_master_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .nack(nack),
    .timeout(timeout), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
    .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata),
    .m_nack(m_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    req_addr[i*7 +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[i*8 +: 8] = wd;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    m_busy = 1'b0; m_done = 1'b0; m_rdata = '0; m_nack = 1'b0;
    tick(); tick();
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_done", done, 4'h0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_flags", {nack, timeout, m_start, m_rw}, 4'h0);
    chk("rst_maddr", m_addr, 7'h00);
    chk("rst_mwdata", m_wdata, 8'h00);
    rst = 1'b0;

    // single write from requester 2
    set_req(2, 7'h50, 1'b0, 8'hA5); req = 4'b0100; tick();
    chk("wr_gnt", gnt, 4'b0100);
    chk("wr_start", m_start, 1'b1);
    chk("wr_maddr", m_addr, 7'h50);
    chk("wr_mwdata", m_wdata, 8'hA5);
    chk("wr_mrw", m_rw, 1'b0);
    req = '0; set_req(2, 7'h11, 1'b1, 8'h00); tick();
    chk("wr_start_once", m_start, 1'b0);
    chk("wr_gnt_hold", gnt, 4'b0100);
    chk("wr_latched", m_addr, 7'h50);
    m_done = 1'b1; m_rdata = 8'hFF; m_nack = 1'b0; tick();
    m_done = 1'b0; m_rdata = 8'h00;
    chk("wr_done", done, 4'b0100);
    chk("wr_gnt_clr", gnt, 4'h0);
    chk("wr_rdata0", rdata, 8'h00);
    chk("wr_flags", {nack, timeout}, 2'b00);
    tick();
    chk("wr_done_pulse", done, 4'h0);

    // read from requester 1 (ptr now 3)
    set_req(1, 7'h21, 1'b1, 8'h00); req = 4'b0010; tick();
    chk("rd_gnt", gnt, 4'b0010);
    chk("rd_mrw", m_rw, 1'b1);
    chk("rd_maddr", m_addr, 7'h21);
    req = '0; tick();
    m_done = 1'b1; m_rdata = 8'h3C; tick();
    m_done = 1'b0; m_rdata = 8'h00;
    chk("rd_done", done, 4'b0010);
    chk("rd_rdata", rdata, 8'h3C);
    tick();
    chk("rd_rdata_hold", rdata, 8'h3C);
    chk("rd_done_pulse", done, 4'h0);

    // master busy blocks a grant
    m_busy = 1'b1; set_req(0, 7'h0A, 1'b0, 8'h01); req = 4'b0001; tick(); tick();
    chk("busy_nogrant", gnt, 4'h0);
    chk("busy_nostart", m_start, 1'b0);
    m_busy = 1'b0; req = '0; tick();
    chk("busy_release", gnt, 4'h0);

    // watchdog: master never completes (ptr now 2, only req 3)
    set_req(3, 7'h33, 1'b1, 8'h77); req = 4'b1000; tick();
    chk("to_start", m_start, 1'b1);
    chk("to_gnt", gnt, 4'b1000);
    req = '0; k = 0;
    while (done == 4'h0 && k < 40) begin tick(); k++; end
    chk("to_latency", k, 17);
    chk("to_done", done, 4'b1000);
    chk("to_flag", timeout, 1'b1);
    chk("to_rdata", rdata, 8'h00);
    chk("to_nack", nack, 1'b0);
    tick();

    // m_done with m_nack on the expiry cycle (ptr now 0)
    set_req(0, 7'h44, 1'b0, 8'h5A); req = 4'b0001; tick();
    chk("tie_gnt", gnt, 4'b0001);
    req = '0;
    repeat (16) tick();
    chk("tie_no_early_done", done, 4'h0);
    m_done = 1'b1; m_nack = 1'b1; tick();
    m_done = 1'b0; m_nack = 1'b0;
    chk("tie_done", done, 4'b0001);
    chk("tie_nack", nack, 1'b1);
    chk("tie_timeout", timeout, 1'b0);
    tick();

    // async reset in WAIT (ptr now 1)
    set_req(2, 7'h66, 1'b0, 8'h01); req = 4'b0100; tick();
    req = '0; tick();
    chk("ar_gnt_pre", gnt, 4'b0100);
    rst = 1'b1; #1;
    chk("ar_gnt_now", gnt, 4'h0);
    chk("ar_maddr", m_addr, 7'h00);
    tick(); tick();
    chk("ar_no_done", done, 4'h0);
    rst = 1'b0;

    // round robin from ptr 0 with all requests held
    for (int i = 0; i < 4; i++) set_req(i, 7'(8'h10 + i), 1'b0, 8'(i));
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      k = 0;
      while (gnt == 4'h0 && k < 8) begin tick(); k++; end
      chk($sformatf("rr_gnt%0d", n), gnt, 32'(4'b0001 << (n % 4)));
      chk($sformatf("rr_addr%0d", n), m_addr, 32'(8'h10 + (n % 4)));
      tick();
      m_done = 1'b1; tick();
      m_done = 1'b0;
      chk($sformatf("rr_done%0d", n), done, 32'(4'b0001 << (n % 4)));
    end
    req = '0; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
